// File: rtl/rangefinder_pkg.sv
// Shared definitions for the rangefinder datapath (pulse generator and echo capture).
package rangefinder_pkg;

  // Counter width shared by the pulse generator delay/length range and the ToF counter.
  localparam int CNT_W_DEFAULT = 17;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/echo_sync_edge.sv
// Synchroniser for an asynchronous comparator output followed by a registered
// rising-edge detector. Total added latency is STAGES+1 cycles; rise is a 1-cycle pulse.
module echo_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              sync_d;

  // Shift the raw input through the synchroniser chain, keep one cycle of history
  // of the synchronised level and register the rising-edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync   <= {sync[STAGES-2:0], din};
      sync_d <= sync[STAGES-1];
      rise   <= sync[STAGES-1] & ~sync_d;
    end
  end

endmodule

// File: rtl/tof_echo_capture.sv
// Time-of-flight capture: counts cycles from the start strobe to the first echo
// rising edge past the blanking window (or to the timeout) and holds the result
// until the consumer accepts it through a valid/ready handshake.
module tof_echo_capture
  import rangefinder_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      blank,
  input  logic [CNT_W-1:0] timeout,
  input  logic             echo_in,
  output logic [CNT_W-1:0] result_tof,
  output logic             result_timeout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             overrun
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      blank_q;
  logic [CNT_W-1:0] timeout_q;
  logic             echo_edge;
  logic             edge_ok;

  echo_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_echo_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (echo_in),
    .rise   (echo_edge)
  );

  // Echo edge counts only once the blanking window has elapsed (zero-extended compare).
  assign edge_ok = echo_edge && (cnt >= CNT_W'(blank_q));

  // Measurement sequencer with counter, latched limits and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      blank_q        <= '0;
      timeout_q      <= '0;
      result_tof     <= '0;
      result_timeout <= 1'b0;
      result_valid   <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      // A start that arrives while a measurement or result is outstanding is dropped.
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            blank_q   <= blank;
            timeout_q <= timeout;
            cnt       <= '0;
            state     <= MEASURE;
            busy      <= 1'b1;
          end
        end
        MEASURE: begin
          if (edge_ok) begin
            // Edge wins over a coincident timeout.
            result_tof     <= cnt;
            result_timeout <= 1'b0;
            result_valid   <= 1'b1;
            state          <= HOLD;
          end else if (cnt == timeout_q) begin
            result_tof     <= timeout_q;
            result_timeout <= 1'b1;
            result_valid   <= 1'b1;
            state          <= HOLD;
          end else begin
            // The timeout check above bounds cnt, so it never wraps.
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tof_echo_capture.sv
// Self-checking bench for tof_echo_capture: directed boundary cases plus randomized
// measurements checked against a waveform-level reference model.
module tb_tof_echo_capture;

  localparam int CNT_W       = 17;
  localparam int SYNC_STAGES = 2;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [15:0]      blank;
  logic [CNT_W-1:0] timeout;
  logic             echo_in;
  logic [CNT_W-1:0] result_tof;
  logic             result_timeout;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  tof_echo_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .blank         (blank),
    .timeout       (timeout),
    .echo_in       (echo_in),
    .result_tof    (result_tof),
    .result_timeout(result_timeout),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Echo waveform, indexed by cycles after the start strobe was driven:
  // a pulse [d1, d1+w) and an optional level that rises at d2 and stays high.
  function automatic bit echo_level(input int d, input int d1, input int w, input int d2);
    return ((d1 >= 0) && (d >= d1) && (d < d1 + w)) || ((d2 >= 0) && (d >= d2));
  endfunction

  // Reference: a rise driven d cycles after start is seen at count d+SYNC_STAGES;
  // the first rise inside [blank, timeout] wins, otherwise the result is the timeout.
  function automatic int model_tof(input int bl, input int to, input int d1, input int d2,
                                   output bit tmo);
    int rises[$];
    if (d1 >= 0) rises.push_back(d1);
    if (d2 >= 0) rises.push_back(d2);
    foreach (rises[i]) begin
      int t = rises[i] + SYNC_STAGES;
      if (t >= bl && t <= to) begin
        tmo = 1'b0;
        return t;
      end
    end
    tmo = 1'b1;
    return to;
  endfunction

  // One measurement; with rdy=1 the result must be consumed after a single valid cycle.
  task automatic run_meas(input string name, input int bl, input int to, input int d1,
                          input int w, input int d2, input bit rdy);
    int exp_tof;
    bit exp_tmo;
    int idx;
    bit seen;
    exp_tof = model_tof(bl, to, d1, d2, exp_tmo);
    result_ready = rdy;
    @(negedge clk);
    start   = 1'b1;
    blank   = 16'(bl);
    timeout = CNT_W'(to);
    echo_in = echo_level(0, d1, w, d2);
    seen = 1'b0;
    idx  = 0;
    while (!seen && idx < to + 20) begin
      @(negedge clk);
      idx++;
      start   = 1'b0;
      blank   = 16'($urandom);
      timeout = CNT_W'($urandom);
      if (idx == 1) check({name, "_busy"}, 32'(busy), 32'd1);
      if (result_valid) seen = 1'b1;
      echo_in = echo_level(idx, d1, w, d2);
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_cycle"}, 32'(idx), 32'(exp_tof + 2));
    check({name, "_tof"}, 32'(result_tof), 32'(exp_tof));
    check({name, "_tmo"}, 32'(result_timeout), 32'(exp_tmo));
    check({name, "_ovr"}, 32'(overrun), 32'd0);
    $display("meas %s: blank=%0d timeout=%0d d1=%0d d2=%0d -> tof=%0d tmo=%0d (exp %0d/%0d)",
             name, bl, to, d1, d2, result_tof, result_timeout, exp_tof, exp_tmo);
    if (rdy) begin
      @(negedge clk);
      check({name, "_valid_drop"}, 32'(result_valid), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
    end
    echo_in = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
  endtask

  initial begin
    int ovr_cnt;
    reset_n      = 1'b0;
    start        = 1'b0;
    blank        = '0;
    timeout      = '0;
    echo_in      = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tof", 32'(result_tof), 32'd0);
    check("rst_tmo", 32'(result_timeout), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    run_meas("basic",      10, 1000, 50, 5, -1, 1'b1);
    run_meas("blanked",   100, 1000, 20, 10, 150, 1'b1);
    run_meas("no_echo",     5,  300, -1, 0, -1, 1'b1);
    run_meas("edge_at_to", 10,   52, 50, 5, -1, 1'b1);
    run_meas("edge_past",  10,   51, 50, 5, -1, 1'b1);
    run_meas("blank_eq",   52, 1000, 50, 5, -1, 1'b1);
    run_meas("blank_gt",   53,  100, 50, 5, -1, 1'b1);
    run_meas("blank_gt_to", 300, 200, 250, 5, -1, 1'b1);

    // Result held with ready low; starts during HOLD are rejected
    run_meas("hold", 10, 1000, 30, 5, -1, 1'b0);
    ovr_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      start = (k == 3 || k == 10);
      @(negedge clk);
      if (overrun) ovr_cnt++;
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_tof", 32'(result_tof), 32'd32);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_ovr", 32'(overrun), 32'(k == 3 || k == 10));
    end
    start = 1'b0;
    check("hold_ovr_count", 32'(ovr_cnt), 32'd2);
    result_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 32'(result_valid), 32'd0);
    check("hold_release_busy", 32'(busy), 32'd0);
    check("hold_keep_tof", 32'(result_tof), 32'd32);
    $display("hold: overrun pulses=%0d", ovr_cnt);

    // timeout=0 ends on the first cycle; start on the transfer cycle is rejected
    run_meas("to_zero", 3, 0, -1, 0, -1, 1'b0);
    result_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("xfer_ovr", 32'(overrun), 32'd1);
    check("xfer_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("xfer_no_restart", 32'(busy), 32'd0);
    check("xfer_ovr_end", 32'(overrun), 32'd0);
    $display("transfer-cycle start: overrun seen, no restart");

    // Asynchronous abort mid-measurement
    @(negedge clk);
    start   = 1'b1;
    blank   = 16'd10;
    timeout = CNT_W'(1000);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_tof", 32'(result_tof), 32'd0);
    check("abort_tmo", 32'(result_timeout), 32'd0);
    $display("abort: busy=%0d valid=%0d tof=%0d", busy, result_valid, result_tof);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_meas("after_abort", 10, 1000, 50, 5, -1, 1'b1);

    // Randomized measurements
    for (int n = 0; n < 25; n++) begin
      int bl, to, d1, w, d2;
      bl = $urandom_range(0, 200);
      to = $urandom_range(0, 400);
      d1 = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 250);
      w  = $urandom_range(1, 20);
      d2 = ($urandom_range(0, 1) == 0 || d1 < 0) ? -1 : d1 + w + $urandom_range(1, 100);
      run_meas($sformatf("rnd%0d", n), bl, to, d1, w, d2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
